// File: rtl/cosim_watchdog_pkg.sv
// Shared state encoding and status byte values for the co-simulation watchdog.
package cosim_watchdog_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_FAIL
    } wd_state_e;

    localparam logic [7:0] STATUS_CONTINUE  = 8'h00;
    localparam logic [7:0] STATUS_DONE      = 8'hFF;
    localparam logic [7:0] STATUS_TIMEOUT   = 8'h01;
    localparam logic [7:0] STATUS_UNDERFLOW = 8'h02;
    localparam logic [7:0] STATUS_OVERFLOW  = 8'h03;
    localparam logic [7:0] STATUS_EXT_BASE  = 8'h10;

    function automatic logic [7:0] ext_status(input logic [3:0] code);
        return STATUS_EXT_BASE | {4'h0, code};
    endfunction

endpackage

// File: rtl/cosim_watchdog_monitor_idle.sv
// Saturating idle-cycle counter; hit fires when the post-update count equals a nonzero limit.
module watchdog_idle_counter #(
    parameter int TIMEOUT_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 activity_i,
    input  logic                 drain_clr_i,
    input  logic [TIMEOUT_W-1:0] limit_i,
    output logic                 hit_o
);

    logic [TIMEOUT_W-1:0] idle_q, idle_d, idle_inc;

    // Saturation keeps a later, smaller limit from matching on a wrapped count.
    always_comb begin
        idle_inc = idle_q;
        if (activity_i)
            idle_inc = '0;
        else if (!(&idle_q))
            idle_inc = idle_q + TIMEOUT_W'(1);
        idle_d = drain_clr_i ? '0 : idle_inc;
    end

    assign hit_o = (limit_i != '0) && (idle_inc == limit_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            idle_q <= '0;
        else
            idle_q <= idle_d;
    end

endmodule

// File: rtl/cosim_watchdog_monitor.sv
// Watchdog poll responder: tracks progress/outstanding work and answers polls with a status byte.
module cosim_watchdog_monitor
    import cosim_watchdog_pkg::*;
#(
    parameter int TIMEOUT_W = 32,
    parameter int OUTST_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
    input  logic                 issue_i,
    input  logic                 retire_i,
    input  logic                 finish_req_i,
    input  logic                 error_req_i,
    input  logic [3:0]           error_code_i,
    input  logic                 poll_valid_i,
    output logic                 status_valid_o,
    output logic [7:0]           status_o,
    output logic [63:0]          cycle_count_o
);

    wd_state_e          state_q, state_d;
    logic [OUTST_W-1:0] outst_q, outst_d;
    logic [7:0]         code_q, code_d;
    logic [7:0]         status_q, status_d;
    logic               status_valid_q;
    logic [63:0]        cycle_q;

    logic inc, dec, underflow, overflow, active, tmo_hit, drain_clr;

    assign inc       = issue_i & ~retire_i;
    assign dec       = retire_i & ~issue_i;
    assign underflow = dec && (outst_q == '0);
    assign overflow  = inc && (&outst_q);
    assign active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign drain_clr = (state_q == ST_RUN) && (state_d == ST_DRAIN);

    watchdog_idle_counter #(.TIMEOUT_W(TIMEOUT_W)) u_idle (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .activity_i  (issue_i | retire_i),
        .drain_clr_i (drain_clr),
        .limit_i     (timeout_cycles_i),
        .hit_o       (tmo_hit)
    );

    // Fault causes are checked in priority order; the first to fire is the one latched.
    always_comb begin
        state_d = state_q;
        outst_d = outst_q;
        code_d  = code_q;
        if (active) begin
            if (inc && !overflow)
                outst_d = outst_q + OUTST_W'(1);
            else if (dec && !underflow)
                outst_d = outst_q - OUTST_W'(1);

            if (error_req_i) begin
                state_d = ST_FAIL;
                code_d  = ext_status(error_code_i);
            end else if (underflow) begin
                state_d = ST_FAIL;
                code_d  = STATUS_UNDERFLOW;
            end else if (overflow) begin
                state_d = ST_FAIL;
                code_d  = STATUS_OVERFLOW;
            end else if (tmo_hit) begin
                state_d = ST_FAIL;
                code_d  = STATUS_TIMEOUT;
            end else if (state_q == ST_RUN && finish_req_i) begin
                state_d = (outst_d == '0) ? ST_DONE : ST_DRAIN;
            end else if (state_q == ST_DRAIN && outst_d == '0) begin
                state_d = ST_DONE;
            end
        end

        case (state_d)
            ST_FAIL: status_d = code_d;
            ST_DONE: status_d = STATUS_DONE;
            default: status_d = STATUS_CONTINUE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_RUN;
            outst_q        <= '0;
            code_q         <= STATUS_CONTINUE;
            status_q       <= STATUS_CONTINUE;
            status_valid_q <= 1'b0;
            cycle_q        <= '0;
        end else begin
            state_q        <= state_d;
            outst_q        <= outst_d;
            code_q         <= code_d;
            status_valid_q <= poll_valid_i;
            cycle_q        <= cycle_q + 64'd1;
            if (poll_valid_i)
                status_q <= status_d;
        end
    end

    assign status_valid_o = status_valid_q;
    assign status_o       = status_q;
    assign cycle_count_o  = cycle_q;

endmodule
